// File: rtl/rat_flag_intr_unit.sv
// Flag register (C/Z with interrupt shadow), global interrupt enable and a
// synchronized, edge-triggered, fixed-priority interrupt pending block.
module rat_flag_intr_unit #(
  parameter  int NUM_SRC     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               ALU_C,
  input  logic               ALU_Z,
  input  logic               FLG_C_SET,
  input  logic               FLG_C_CLR,
  input  logic               FLG_C_LD,
  input  logic               FLG_Z_LD,
  input  logic               FLG_LD_SEL,
  input  logic               FLG_SHAD_LD,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic [NUM_SRC-1:0] INT_IN,
  output logic               C_FLAG,
  output logic               Z_FLAG,
  output logic               I_EN,
  output logic               INT_R,
  output logic [IDW-1:0]     INT_ID
);

  logic c_q, c_d, z_q, z_d;
  logic shad_c_q, shad_c_d, shad_z_q, shad_z_d;
  logic i_en_q, i_en_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [IDW-1:0]     int_id_q, int_id_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] rise;
  logic [IDW-1:0]     ack_idx;
  logic               ack_any;

  always_comb begin
    c_d      = c_q;
    z_d      = z_q;
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    i_en_d   = i_en_q;

    if (FLG_LD_SEL)     c_d = shad_c_q;
    else if (FLG_C_CLR) c_d = 1'b0;
    else if (FLG_C_SET) c_d = 1'b1;
    else if (FLG_C_LD)  c_d = ALU_C;

    if (FLG_LD_SEL)    z_d = shad_z_q;
    else if (FLG_Z_LD) z_d = ALU_Z;

    // Shadow samples pre-edge flags, so LD_SEL + SHAD_LD together swaps them.
    if (FLG_SHAD_LD) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end

    if (FLG_SHAD_LD)  i_en_d = 1'b0;
    else if (I_CLR)   i_en_d = 1'b0;
    else if (I_SET)   i_en_d = 1'b1;
  end

  always_comb begin
    sync_d[0] = INT_IN;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Index 0 is the highest priority, so scan downward and keep the last hit.
  always_comb begin
    ack_idx = '0;
    ack_any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        ack_idx = IDW'(i);
        ack_any = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    int_id_d = int_id_q;
    if (FLG_SHAD_LD && ack_any) begin
      pend_d[ack_idx] = 1'b0;
      int_id_d        = ack_idx;
    end
    // A new edge landing on the bit being acknowledged must not be lost.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      i_en_q   <= 1'b0;
      pend_q   <= '0;
      int_id_q <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      i_en_q   <= i_en_d;
      pend_q   <= pend_d;
      int_id_q <= int_id_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
    end
  end

  assign C_FLAG = c_q;
  assign Z_FLAG = z_q;
  assign I_EN   = i_en_q;
  assign INT_R  = i_en_q & (|pend_q);
  assign INT_ID = int_id_q;

endmodule

// File: tb/tb_rat_flag_intr_unit.sv
// Directed scenarios plus a random phase, all checked against a cycle-level
// reference model of the flag and interrupt rules.
module tb_rat_flag_intr_unit;
  localparam int NSRC = 4;
  localparam int SYNC = 2;

  logic CLK = 1'b0;
  logic RESET_N;
  logic ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
  logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR;
  logic [NSRC-1:0] INT_IN;
  logic C_FLAG, Z_FLAG, I_EN, INT_R;
  logic [1:0] INT_ID;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_c, m_z, m_sc, m_sz, m_i;
  bit [NSRC-1:0] m_pend;
  int m_id;
  bit [NSRC-1:0] m_hist [0:SYNC]; // m_hist[0] = pins sampled at the latest edge

  rat_flag_intr_unit #(.NUM_SRC(NSRC), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
    .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_IN(INT_IN), .C_FLAG(C_FLAG),
    .Z_FLAG(Z_FLAG), .I_EN(I_EN), .INT_R(INT_R), .INT_ID(INT_ID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_z = 0; m_sc = 0; m_sz = 0; m_i = 0; m_pend = '0; m_id = 0;
    for (int j = 0; j <= SYNC; j++) m_hist[j] = '0;
  endtask

  task automatic model_edge();
    bit nc, nz;
    bit [NSRC-1:0] ev;
    // A pin seen high SYNC edges ago and low the edge before that is a new request.
    ev = m_hist[SYNC-1] & ~m_hist[SYNC];
    nc = FLG_LD_SEL ? m_sc : FLG_C_CLR ? 1'b0 : FLG_C_SET ? 1'b1 : FLG_C_LD ? ALU_C : m_c;
    nz = FLG_LD_SEL ? m_sz : FLG_Z_LD ? ALU_Z : m_z;
    if (FLG_SHAD_LD) begin m_sc = m_c; m_sz = m_z; end
    m_c = nc; m_z = nz;
    if (FLG_SHAD_LD || I_CLR) m_i = 0; else if (I_SET) m_i = 1;
    if (FLG_SHAD_LD && m_pend != 0) begin
      for (int k = 0; k < NSRC; k++)
        if (m_pend[k]) begin m_pend[k] = 0; m_id = k; break; end
    end
    m_pend |= ev;
    for (int j = SYNC; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = INT_IN;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".C"}, C_FLAG, m_c);
    chk({tag, ".Z"}, Z_FLAG, m_z);
    chk({tag, ".I"}, I_EN, m_i);
    chk({tag, ".R"}, INT_R, m_i & (|m_pend));
    chk({tag, ".ID"}, INT_ID, m_id);
  endtask

  task automatic clr_strobes();
    FLG_C_SET = 0; FLG_C_CLR = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
    FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0;
  endtask

  // one clock: model follows the DUT edge, outputs sampled 1 ns later, strobes then dropped
  task automatic step(input string tag);
    @(posedge CLK);
    if (RESET_N) model_edge();
    #1;
    check_all(tag);
    clr_strobes();
  endtask

  initial begin
    RESET_N = 0; ALU_C = 0; ALU_Z = 0; INT_IN = '0;
    clr_strobes();
    model_reset();
    #1;
    check_all("por");
    step("por");
    #2 RESET_N = 1;
    step("idle");

    // T1: build C=Z=I=1, PEND=0101, then reset asynchronously mid-cycle
    FLG_C_SET = 1; ALU_Z = 1; FLG_Z_LD = 1; I_SET = 1; INT_IN = 4'b0101;
    step("t1.setup");
    INT_IN = 4'b0000;
    for (int n = 0; n < 4; n++) step("t1.wait");
    chk("t1.pre_int_r", INT_R, 1);
    #2 RESET_N = 0;
    model_reset();
    #1;
    chk("t1.async_c", C_FLAG, 0);
    chk("t1.async_z", Z_FLAG, 0);
    chk("t1.async_i", I_EN, 0);
    chk("t1.async_r", INT_R, 0);
    step("t1.hold");
    step("t1.hold");
    #2 RESET_N = 1;
    I_SET = 1;
    step("t1.rel");
    chk("t1.pend_gone", INT_R, 0);

    // T2: C priority
    FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 1;
    step("t2.a");
    chk("t2.c_clr_wins", C_FLAG, 0);
    FLG_C_SET = 1; FLG_C_LD = 1; ALU_C = 0;
    step("t2.b");
    chk("t2.c_set_wins", C_FLAG, 1);

    // T3: shadow save / restore
    ALU_Z = 0; FLG_Z_LD = 1;
    step("t3.z0");
    FLG_SHAD_LD = 1;
    step("t3.shad");
    ALU_C = 0; ALU_Z = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
    step("t3.ld");
    chk("t3.c0", C_FLAG, 0);
    chk("t3.z1", Z_FLAG, 1);
    FLG_LD_SEL = 1;
    step("t3.rest");
    chk("t3.c_rest", C_FLAG, 1);
    chk("t3.z_rest", Z_FLAG, 0);

    // T4: latency while masked, then unmask and ack
    I_CLR = 1;
    step("t4.mask");
    INT_IN[2] = 1;
    step("t4.e0");
    step("t4.e1");
    step("t4.e2");
    chk("t4.masked_r", INT_R, 0);
    I_SET = 1;
    step("t4.iset");
    chk("t4.int_r", INT_R, 1);
    FLG_SHAD_LD = 1;
    step("t4.ack");
    chk("t4.id", INT_ID, 2);
    chk("t4.i_en", I_EN, 0);
    chk("t4.r_low", INT_R, 0);

    // T5: priority between two simultaneous sources
    INT_IN = '0; I_SET = 1;
    for (int n = 0; n < 3; n++) step("t5.quiet");
    INT_IN = 4'b1010;
    for (int n = 0; n < 3; n++) step("t5.sync");
    FLG_SHAD_LD = 1;
    step("t5.ack1");
    chk("t5.id1", INT_ID, 1);
    I_SET = 1;
    step("t5.iset");
    chk("t5.r_again", INT_R, 1);
    FLG_SHAD_LD = 1;
    step("t5.ack2");
    chk("t5.id3", INT_ID, 3);

    // T6: new edge on bit 0 arrives in the same cycle as its ack
    INT_IN = 4'b0001; I_SET = 1;
    for (int n = 0; n < 3; n++) step("t6.first");
    INT_IN = 4'b0000;
    for (int n = 0; n < 3; n++) step("t6.low");
    INT_IN = 4'b0001;
    step("t6.n");
    step("t6.n1");
    FLG_SHAD_LD = 1;
    step("t6.collide");
    chk("t6.id0", INT_ID, 0);
    chk("t6.r_masked", INT_R, 0);
    I_SET = 1;
    step("t6.iset");
    chk("t6.r_reassert", INT_R, 1);

    // random phase
    for (int n = 0; n < 400; n++) begin
      ALU_C       = 1'($urandom);
      ALU_Z       = 1'($urandom);
      FLG_C_SET   = ($urandom_range(0, 5) == 0);
      FLG_C_CLR   = ($urandom_range(0, 5) == 0);
      FLG_C_LD    = ($urandom_range(0, 3) == 0);
      FLG_Z_LD    = ($urandom_range(0, 3) == 0);
      FLG_LD_SEL  = ($urandom_range(0, 7) == 0);
      FLG_SHAD_LD = ($urandom_range(0, 5) == 0);
      I_SET       = ($urandom_range(0, 3) == 0);
      I_CLR       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) INT_IN[$urandom_range(0, NSRC-1)] ^= 1'b1;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
